// File: rtl/split_sched_pkg.sv
// split_sched_pkg: shared state encoding and digit constants for the BCD splitter
package split_sched_pkg;
  typedef enum logic [1:0] {IDLE, HUN, TEN, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam int MAX_VAL_DEF = 999;
endpackage

// File: rtl/split_sched_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] j;
  assign any = |req;
  // scan from the farthest slot back toward ptr so the nearest set request wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      idx = req[j] ? j : idx;
    end
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/split_sched.sv
// split_sched: shared multi-cycle binary-to-BCD splitter arbitrated round-robin among clients
module split_sched
  import split_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int VAL_W = 10,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*VAL_W-1:0] val,
  output logic [NREQ-1:0]       ack,
  output logic [DIGIT_W-1:0]    hund,
  output logic [DIGIT_W-1:0]    tens,
  output logic [DIGIT_W-1:0]    ones,
  output logic                  err,
  output logic                  busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t st;
  logic [VAL_W-1:0] rem, v;
  logic [DIGIT_W-1:0] h, t;
  logic ovf, big, any;
  logic [NREQ-1:0] gnt, sel;
  logic [IW-1:0] idx, gidx, ptr;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  assign v = val[idx*VAL_W +: VAL_W];
  assign big = v > VAL_W'(MAX_VAL);
  assign busy = st != IDLE;
  // sequencer: grant and latch, subtract hundreds then tens, publish digits with a one-cycle ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      gidx <= '0;
      sel <= '0;
      rem <= '0;
      h <= '0;
      t <= '0;
      ovf <= 1'b0;
      ack <= '0;
      hund <= '0;
      tens <= '0;
      ones <= '0;
      err <= 1'b0;
    end else
      case (st)
        IDLE:
          if (any) begin
            sel <= gnt;
            gidx <= idx;
            h <= '0;
            t <= '0;
            ovf <= big;
            rem <= big ? VAL_W'(MAX_VAL) : v;
            st <= HUN;
          end
        HUN:
          if (rem >= VAL_W'(100)) begin
            rem <= rem - VAL_W'(100);
            h <= h + 1'b1;
          end else
            st <= TEN;
        TEN:
          if (rem >= VAL_W'(10)) begin
            rem <= rem - VAL_W'(10);
            t <= t + 1'b1;
          end else begin
            hund <= h;
            tens <= t;
            ones <= rem[DIGIT_W-1:0];
            err <= ovf;
            ack <= sel;
            ptr <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
            st <= DONE;
          end
        DONE: begin
          ack <= '0;
          err <= 1'b0;
          st <= IDLE;
        end
      endcase
endmodule
